// File: rtl/flash_responder.sv
// Serial nibble flash read responder: one 16-bit word from four 4-bit fetches.
// Optional last-address cache is enabled by defining FLASH_CACHE_EN.
module flash_responder (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        flash_ready,
    input  logic [15:0] flash_address,
    output logic [15:0] flash_data_out,
    output logic        data_valid,
    output logic        busy,
    output logic [17:0] mem_addr,
    output logic        mem_ce_n,
    output logic        mem_oe_n,
    input  logic [3:0]  mem_dq
);

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        SAMPLE,
        DONE
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [1:0]  n;
    logic [15:0] addr_q;
    logic [11:0] buf_q;
    logic        hit;
    logic        start;
    logic        last;

`ifdef FLASH_CACHE_EN
    logic [15:0] cache_addr;
    logic        cache_valid;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cache_addr  <= '0;
            cache_valid <= 1'b0;
        end else if (last) begin
            cache_addr  <= addr_q;
            cache_valid <= 1'b1;
        end
    end

    assign hit = cache_valid && (flash_address == cache_addr);
`else
    assign hit = 1'b0;
`endif

    assign start = flash_ready && !hit &&
                   ((state == IDLE) || (state == DONE));
    assign last  = (state == SAMPLE) && (n == 2'd3);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        busy       = 1'b1;
        data_valid = 1'b0;
        mem_ce_n   = 1'b1;
        mem_oe_n   = 1'b1;
        unique case (state)
            IDLE, DONE: begin
                busy       = (state == DONE);
                data_valid = (state == DONE);
                if (flash_ready) state_nx = hit ? DONE : ADDR;
                else             state_nx = IDLE;
            end
            ADDR: begin
                mem_ce_n = 1'b0;
                mem_oe_n = 1'b0;
                state_nx = SAMPLE;
            end
            SAMPLE: begin
                mem_ce_n = 1'b0;
                mem_oe_n = 1'b0;
                state_nx = (n == 2'd3) ? DONE : ADDR;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Nibble 0 lands in the top of the word; the last one completes it.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            addr_q         <= '0;
            n              <= '0;
            buf_q          <= '0;
            flash_data_out <= '0;
        end else begin
            if (start) begin
                addr_q <= flash_address;
                n      <= 2'd0;
            end
            if (state == SAMPLE) begin
                unique case (n)
                    2'd0: buf_q[11:8] <= mem_dq;
                    2'd1: buf_q[7:4]  <= mem_dq;
                    2'd2: buf_q[3:0]  <= mem_dq;
                    2'd3: flash_data_out <= {buf_q, mem_dq};
                endcase
                if (n != 2'd3) n <= n + 2'd1;
            end
        end
    end

    assign mem_addr = {addr_q, n};

endmodule

// File: tb/tb_flash_responder.sv
// Randomized self-checking bench for flash_responder with a word-level
// flash model and a transaction-level expectation model.
module tb_flash_responder;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        flash_ready;
    logic [15:0] flash_address;
    logic [15:0] flash_data_out;
    logic        data_valid;
    logic        busy;
    logic [17:0] mem_addr;
    logic        mem_ce_n;
    logic        mem_oe_n;
    logic [3:0]  mem_dq;
    logic [15:0] mem_word;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] m_dout;
    logic [17:0] m_maddr;
    logic [15:0] m_addr;
    bit          m_valid;

    always #5 clk = ~clk;

    flash_responder dut (
        .clk            (clk),
        .n_rst          (n_rst),
        .flash_ready    (flash_ready),
        .flash_address  (flash_address),
        .flash_data_out (flash_data_out),
        .data_valid     (data_valid),
        .busy           (busy),
        .mem_addr       (mem_addr),
        .mem_ce_n       (mem_ce_n),
        .mem_oe_n       (mem_oe_n),
        .mem_dq         (mem_dq)
    );

    function automatic logic [15:0] word_of(input logic [15:0] a);
        if (a == 16'h0010) return 16'hA5C3;
        if (a == 16'h0011) return 16'h1234;
        return a ^ 16'hC3A5 ^ {a[7:0], a[15:8]};
    endfunction

    // External flash: nibble 0 is the most significant nibble of the word
    always_comb begin
        mem_word = word_of(mem_addr[17:2]);
        case (mem_addr[1:0])
            2'd0:    mem_dq = mem_word[15:12];
            2'd1:    mem_dq = mem_word[11:8];
            2'd2:    mem_dq = mem_word[7:4];
            default: mem_dq = mem_word[3:0];
        endcase
    end

    task automatic model_reset();
        m_dout  = '0;
        m_maddr = '0;
        m_addr  = '0;
        m_valid = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        n_rst         = 1'b0;
        flash_ready   = 1'b0;
        flash_address = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
    endtask

    // Drives a request in the current cycle, checks every cycle up to the
    // data_valid cycle and returns positioned in that cycle.
    task automatic run_read(input logic [15:0] a, input int inj,
                            input logic [15:0] ia, input string tag);
        bit          hit;
        int          lat;
        logic [1:0]  nn;
        logic [37:0] got;
        logic [37:0] exp;
`ifdef FLASH_CACHE_EN
        hit = m_valid && (a == m_addr);
`else
        hit = 1'b0;
`endif
        lat           = hit ? 1 : 9;
        flash_ready   = 1'b1;
        flash_address = a;
        for (int j = 1; j <= lat; j++) begin
            @(negedge clk);
            if (j < lat) begin
                nn  = 2'((j - 1) / 2);
                exp = {4'b1000, a, nn, m_dout};
            end else begin
                if (!hit) begin
                    m_dout  = word_of(a);
                    m_maddr = {a, 2'd3};
                    m_addr  = a;
                    m_valid = 1'b1;
                end
                exp = {4'b1111, m_maddr, m_dout};
            end
            got = {busy, data_valid, mem_ce_n, mem_oe_n,
                   mem_addr, flash_data_out};
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL %s cyc%0d {busy,dv,ce_n,oe_n,addr,dout}: got %h want %h",
                         tag, j, got, exp);
            end
            flash_ready   = (j == inj);
            flash_address = (j == inj) ? ia : 16'($urandom);
        end
        flash_ready = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        logic [37:0] got;
        logic [37:0] exp;
        @(negedge clk);
        exp = {4'b0011, m_maddr, m_dout};
        got = {busy, data_valid, mem_ce_n, mem_oe_n,
               mem_addr, flash_data_out};
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s idle: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic test_reset();
        n_rst         = 1'b0;
        flash_ready   = 1'b0;
        flash_address = '0;
        model_reset();
        #1;
        n_cmp++;
        if ({busy, data_valid, mem_ce_n, mem_oe_n} !== 4'b0011) begin
            n_bad++;
            $display("FAIL reset ctrl: got %b want 0011",
                     {busy, data_valid, mem_ce_n, mem_oe_n});
        end
        n_cmp++;
        if (mem_addr !== 18'h0) begin
            n_bad++;
            $display("FAIL reset mem_addr: got %h want 0", mem_addr);
        end
        n_cmp++;
        if (flash_data_out !== 16'h0) begin
            n_bad++;
            $display("FAIL reset dout: got %h want 0", flash_data_out);
        end
        @(negedge clk);
        n_rst = 1'b1;
        check_idle("reset_release");
    endtask

    task automatic test_single();
        apply_reset();
        run_read(16'h0010, 0, 16'h0, "single");
        check_idle("single_after");
    endtask

    task automatic test_back_to_back();
        apply_reset();
        run_read(16'h0010, 0, 16'h0, "b2b_first");
        run_read(16'h0011, 0, 16'h0, "b2b_second");
        check_idle("b2b_after");
    endtask

    task automatic test_busy_ignore();
        apply_reset();
        run_read(16'h0010, 3, 16'h00FF, "busy_ign");
        check_idle("busy_ign_after");
        check_idle("busy_ign_after2");
    endtask

    task automatic test_wrap();
        apply_reset();
        run_read(16'hFFFF, 0, 16'h0, "wrap");
        n_cmp++;
        if (mem_addr !== 18'h3FFFF) begin
            n_bad++;
            $display("FAIL wrap mem_addr: got %h want 3ffff", mem_addr);
        end
        check_idle("wrap_after");
    endtask

    task automatic test_reset_mid();
        apply_reset();
        flash_ready   = 1'b1;
        flash_address = 16'h0010;
        for (int j = 1; j <= 5; j++) begin
            @(negedge clk);
            flash_ready = 1'b0;
        end
        n_rst = 1'b0;
        #1;
        n_cmp++;
        if ({busy, data_valid, mem_ce_n, mem_oe_n, mem_addr, flash_data_out}
            !== {4'b0011, 18'h0, 16'h0}) begin
            n_bad++;
            $display("FAIL rst_mid async: got %b %h %h want 0011 0 0",
                     {busy, data_valid, mem_ce_n, mem_oe_n},
                     mem_addr, flash_data_out);
        end
        model_reset();
        @(negedge clk);
        @(negedge clk);
        n_rst = 1'b1;
        for (int j = 0; j < 12; j++) begin
            check_idle("rst_mid_quiet");
        end
    endtask

    task automatic test_cache();
        apply_reset();
        run_read(16'h0010, 0, 16'h0, "cache_fill");
        check_idle("cache_fill_after");
        run_read(16'h0010, 0, 16'h0, "cache_repeat");
        check_idle("cache_repeat_after");
        run_read(16'h0011, 0, 16'h0, "cache_other");
        run_read(16'h0011, 0, 16'h0, "cache_b2b_repeat");
        check_idle("cache_end");
    endtask

    task automatic test_random();
        logic [15:0] a;
        int          gap;
        apply_reset();
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0:       a = 16'h0010;
                1:       a = 16'h0011;
                2:       a = 16'hFFFF;
                default: a = 16'($urandom);
            endcase
            run_read(a, ($urandom_range(0, 1) == 1) ? $urandom_range(1, 8) : 0,
                     16'($urandom), "random");
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) check_idle("random_gap");
        end
        check_idle("random_end");
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_busy_ignore();
        test_wrap();
        test_reset_mid();
        test_cache();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
